// File: rtl/stream_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : stream_frame_arbiter
//  Function : Frame-granular round-robin arbiter feeding one stencil-stream
//             consumer from two producers. Locks the grant for a full frame,
//             regenerates tlast from the image/stencil extents, flags
//             producers whose own tlast disagrees, and sequences a run of
//             NUM_FRAMES frames per start_in pulse.
//  Revision : 1.0  initial release
// ============================================================================
module stream_frame_arbiter #(
  parameter int IMG_EXTENT_0 = 256,
  parameter int IMG_EXTENT_1 = 256,
  parameter int IMG_EXTENT_2 = 1,
  parameter int IMG_EXTENT_3 = 1,
  parameter int ST_EXTENT_0  = 1,
  parameter int ST_EXTENT_1  = 1,
  parameter int ST_EXTENT_2  = 1,
  parameter int ST_EXTENT_3  = 1,
  parameter int DATA_SIZE    = 8,
  parameter int NUM_FRAMES   = 4,
  localparam int BEATS = (IMG_EXTENT_0 / ST_EXTENT_0) * (IMG_EXTENT_1 / ST_EXTENT_1) *
                         (IMG_EXTENT_2 / ST_EXTENT_2) * (IMG_EXTENT_3 / ST_EXTENT_3),
  localparam int W     = DATA_SIZE * ST_EXTENT_0 * ST_EXTENT_1 * ST_EXTENT_2 * ST_EXTENT_3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_in,
  input  logic [W-1:0] s0_tdata,
  input  logic         s0_tvalid,
  input  logic         s0_tlast,
  output logic         s0_tready,
  input  logic [W-1:0] s1_tdata,
  input  logic         s1_tvalid,
  input  logic         s1_tlast,
  output logic         s1_tready,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  output logic         m_tlast,
  input  logic         m_tready,
  output logic         grant_id,
  output logic         frame_done,
  output logic [1:0]   err_tlast,
  output logic         busy,
  output logic         stop_out
);

  localparam int BW = $clog2(BEATS + 1);
  localparam logic [BW-1:0] C_LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [15:0]   C_LAST_FRAME = 16'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE_OFF = 2'd0,
    ARB      = 2'd1,
    GRANT    = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          r_grant;
  logic          r_last_served;
  logic [BW-1:0] r_beat_cnt;
  logic [15:0]   r_frame_cnt;
  logic [1:0]    r_err_tlast;
  logic          r_busy;
  logic          r_stop;

  logic [W-1:0]  w_sg_tdata;
  logic          w_sg_tvalid;
  logic          w_sg_tlast;
  logic          w_beat_is_last;
  logic          w_last_frame;
  logic          w_pick;
  logic          w_hs;
  logic          w_final;

  // Select the granted producer's stream and precompute frame-position flags
  always_comb begin
    w_sg_tdata     = r_grant ? s1_tdata  : s0_tdata;
    w_sg_tvalid    = r_grant ? s1_tvalid : s0_tvalid;
    w_sg_tlast     = r_grant ? s1_tlast  : s0_tlast;
    w_beat_is_last = (r_beat_cnt == C_LAST_BEAT);
    w_last_frame   = (r_frame_cnt == C_LAST_FRAME);
    // A tie goes to whichever producer was not served last
    w_pick         = (s0_tvalid & s1_tvalid) ? ~r_last_served : s1_tvalid;
  end

  // Next-state logic plus the zero-latency granted datapath
  always_comb begin
    w_next_state = r_state;
    m_tvalid     = 1'b0;
    m_tdata      = '0;
    m_tlast      = 1'b0;
    s0_tready    = 1'b0;
    s1_tready    = 1'b0;
    w_hs         = 1'b0;
    w_final      = 1'b0;
    case (r_state)
      IDLE_OFF: begin
        if (start_in) w_next_state = ARB;
      end
      ARB: begin
        if (s0_tvalid | s1_tvalid) w_next_state = GRANT;
      end
      GRANT: begin
        m_tvalid  = w_sg_tvalid;
        m_tdata   = w_sg_tdata;
        m_tlast   = w_beat_is_last;
        s0_tready = ~r_grant & m_tready;
        s1_tready =  r_grant & m_tready;
        w_hs      = w_sg_tvalid & m_tready;
        w_final   = w_hs & w_beat_is_last;
        if (w_final) w_next_state = w_last_frame ? IDLE_OFF : ARB;
      end
      default: w_next_state = IDLE_OFF;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE_OFF;
    else       r_state <= w_next_state;
  end

  // Grant, beat/frame counters, tlast-error flags and run sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant       <= 1'b0;
      r_last_served <= 1'b1;  // makes producer 0 win the first tie
      r_beat_cnt    <= '0;
      r_frame_cnt   <= '0;
      r_err_tlast   <= 2'b00;
      r_busy        <= 1'b0;
      r_stop        <= 1'b0;
    end else begin
      if (r_state == IDLE_OFF && start_in) begin
        r_frame_cnt <= '0;
        r_stop      <= 1'b0;
        r_busy      <= 1'b1;
      end
      if (r_state == ARB && (s0_tvalid | s1_tvalid)) begin
        r_grant <= w_pick;
      end
      if (w_hs) begin
        r_beat_cnt <= r_beat_cnt + BW'(1);
        if (w_sg_tlast != m_tlast) r_err_tlast[r_grant] <= 1'b1;
      end
      if (w_final) begin
        r_beat_cnt    <= '0;
        r_frame_cnt   <= r_frame_cnt + 16'd1;
        r_last_served <= r_grant;
        if (w_last_frame) begin
          r_busy <= 1'b0;
          r_stop <= 1'b1;
        end
      end
    end
  end

  assign grant_id   = r_grant;
  assign frame_done = w_final;
  assign err_tlast  = r_err_tlast;
  assign busy       = r_busy;
  assign stop_out   = r_stop;

endmodule
`default_nettype wire

// File: tb/tb_stream_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_frame_arbiter
//  Function : Self-checking bench for stream_frame_arbiter (4x2 image,
//             unit stencil, 8-bit data, two frames per run).
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_frame_arbiter;

  localparam int NF    = 2;
  localparam int BEATS = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_in = 1'b0;
  logic [7:0] s0_tdata, s1_tdata, m_tdata;
  logic       s0_tvalid, s0_tlast, s0_tready;
  logic       s1_tvalid, s1_tlast, s1_tready;
  logic       m_tvalid, m_tlast, m_tready;
  logic       grant_id, frame_done, busy, stop_out;
  logic [1:0] err_tlast;

  stream_frame_arbiter #(
    .IMG_EXTENT_0(4), .IMG_EXTENT_1(2), .IMG_EXTENT_2(1), .IMG_EXTENT_3(1),
    .ST_EXTENT_0(1), .ST_EXTENT_1(1), .ST_EXTENT_2(1), .ST_EXTENT_3(1),
    .DATA_SIZE(8), .NUM_FRAMES(NF)
  ) dut (
    .clk(clk), .reset(reset), .start_in(start_in),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant_id(grant_id), .frame_done(frame_done), .err_tlast(err_tlast),
    .busy(busy), .stop_out(stop_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Producer models: each queue holds the word its producer is presenting
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [6:0] seq0, seq1;
  int         pb0, pb1;
  bit         en0, en1, stall, rnd_ready, bad1;

  // Consumer-side observation state
  int   cyc = 0;
  int   mb, in_frame, frames, hs_total, fd_cnt, last_end_cyc;
  logic mg;
  logic grants[$];
  int   gaps[$];

  task automatic model_reset();
    q0.delete(); q1.delete();
    seq0 = '0; seq1 = '0; pb0 = 0; pb1 = 0;
    mb = 0; in_frame = 0;
    q0.push_back({1'b0, seq0});
    q1.push_back({1'b1, seq1});
  endtask

  task automatic clear_counts();
    frames = 0; hs_total = 0; fd_cnt = 0;
    grants.delete(); gaps.delete();
  endtask

  task automatic drive_inputs();
    s0_tdata  = {1'b0, seq0};
    s0_tlast  = (pb0 == BEATS - 1);
    s1_tdata  = {1'b1, seq1};
    s1_tlast  = bad1 ? (pb1 == 4) : (pb1 == BEATS - 1);
    s0_tvalid = en0 && (!stall || $urandom_range(0, 3) != 0);
    s1_tvalid = en1 && (!stall || $urandom_range(0, 3) != 0);
    m_tready  = !rnd_ready || $urandom_range(0, 1) == 1;
  endtask

  // One clock: observe/score at negedge, then update producers after posedge
  task automatic cycle();
    logic [7:0] exp_d;
    logic       c0, c1, exp_last;
    @(negedge clk);
    cyc++;
    if (frame_done === 1'b1) fd_cnt++;
    c0 = s0_tvalid & s0_tready;
    c1 = s1_tvalid & s1_tready;
    if (!reset && m_tvalid === 1'b1 && m_tready) begin
      hs_total++;
      if (!in_frame) begin
        in_frame = 1;
        mg = grant_id;
        grants.push_back(grant_id);
        gaps.push_back(cyc - last_end_cyc);
      end else begin
        checks++;
        if (grant_id !== mg) begin
          errors++; $display("FAIL grant_hold: got %0d expected %0d", grant_id, mg);
        end
      end
      checks++;
      if (s0_tready !== !mg || s1_tready !== mg) begin
        errors++; $display("FAIL tready_sel: got s0=%0d s1=%0d grant %0d", s0_tready, s1_tready, mg);
      end
      checks++;
      if ((mg ? q1.size() : q0.size()) == 0) begin
        errors++; $display("FAIL data_order: got %0h with empty queue", m_tdata);
      end else begin
        exp_d = mg ? q1.pop_front() : q0.pop_front();
        if (m_tdata !== exp_d) begin
          errors++; $display("FAIL data_order: got %0h expected %0h", m_tdata, exp_d);
        end
      end
      exp_last = (mb == BEATS - 1);
      checks++;
      if (m_tlast !== exp_last) begin
        errors++; $display("FAIL m_tlast beat %0d: got %0d expected %0d", mb, m_tlast, exp_last);
      end
      checks++;
      if (frame_done !== exp_last) begin
        errors++; $display("FAIL frame_done beat %0d: got %0d expected %0d", mb, frame_done, exp_last);
      end
      mb++;
      if (mb == BEATS) begin
        mb = 0; in_frame = 0; frames++; last_end_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else begin
      if (c0) begin pb0 = (pb0 + 1) % BEATS; seq0++; q0.push_back({1'b0, seq0}); end
      if (c1) begin pb1 = (pb1 + 1) % BEATS; seq1++; q1.push_back({1'b1, seq1}); end
    end
    drive_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    cycle();
    start_in = 1'b0;
    last_end_cyc = cyc;
  endtask

  task automatic wait_frames(input int target, input int bound);
    int n = 0;
    while (frames < target && n < bound) begin cycle(); n++; end
    checks++;
    if (frames < target) begin
      errors++; $display("FAIL frame_timeout: got %0d expected %0d", frames, target);
    end
  endtask

  task automatic wait_beats(input int target, input int bound);
    int n = 0;
    while (hs_total < target && n < bound) begin cycle(); n++; end
    checks++;
    if (hs_total < target) begin
      errors++; $display("FAIL beat_timeout: got %0d expected %0d", hs_total, target);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({m_tvalid, m_tlast, s0_tready, s1_tready, grant_id, frame_done, busy, stop_out} !== 8'h00
        || err_tlast !== 2'b00 || m_tdata !== 8'h00) begin
      errors++;
      $display("FAIL %s: got tv=%0d tl=%0d r0=%0d r1=%0d g=%0d fd=%0d busy=%0d stop=%0d err=%0b data=%0h expected all 0",
               tag, m_tvalid, m_tlast, s0_tready, s1_tready, grant_id, frame_done, busy, stop_out, err_tlast, m_tdata);
    end
  endtask

  task automatic test_reset();
    en0 = 0; en1 = 0; stall = 0; rnd_ready = 0; bad1 = 0;
    do_reset();
    check_all_zero("reset_state");
  endtask

  task automatic test_single_producer();
    do_reset(); clear_counts();
    en0 = 1; en1 = 0; drive_inputs();
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %0d expected 1", busy); end
    wait_frames(2, 100);
    checks++;
    if (stop_out !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL run_end: got stop=%0d busy=%0d expected stop=1 busy=0", stop_out, busy);
    end
    checks++;
    if (hs_total != 16 || fd_cnt != 2) begin
      errors++; $display("FAIL single_counts: got beats=%0d pulses=%0d expected 16 and 2", hs_total, fd_cnt);
    end
    checks++;
    if (gaps.size() != 2 || gaps[0] != 2 || gaps[1] != 2) begin
      errors++; $display("FAIL arb_latency: got %0d entries first=%0d expected gaps of 2",
                         gaps.size(), (gaps.size() > 0) ? gaps[0] : -1);
    end
    checks++;
    if (grants.size() != 2 || grants[0] !== 1'b0 || grants[1] !== 1'b0) begin
      errors++; $display("FAIL single_grant: got %0d frames expected two grants to 0", grants.size());
    end
  endtask

  task automatic test_back_to_back();
    logic exp_g;
    do_reset(); clear_counts();
    en0 = 1; en1 = 1; drive_inputs();
    pulse_start(); wait_frames(2, 100);
    pulse_start(); wait_frames(4, 100);
    checks++;
    if (grants.size() != 4 || hs_total != 32) begin
      errors++; $display("FAIL b2b_counts: got frames=%0d beats=%0d expected 4 and 32", grants.size(), hs_total);
    end
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      exp_g = (i % 2 == 1);
      checks++;
      if (grants[i] !== exp_g) begin
        errors++; $display("FAIL rr_order frame %0d: got %0d expected %0d", i, grants[i], exp_g);
      end
    end
  endtask

  task automatic test_tlast_err();
    do_reset(); clear_counts();
    en0 = 0; en1 = 1; bad1 = 1; drive_inputs();
    pulse_start(); wait_frames(1, 100);
    checks++;
    if (err_tlast !== 2'b10) begin errors++; $display("FAIL err_set: got %0b expected 10", err_tlast); end
    wait_frames(2, 100);
    bad1 = 0; en0 = 1; en1 = 0; drive_inputs();
    pulse_start(); wait_frames(4, 100);
    checks++;
    if (err_tlast !== 2'b10) begin errors++; $display("FAIL err_sticky: got %0b expected 10", err_tlast); end
    checks++;
    if (grants.size() != 4 || grants[0] !== 1'b1 || grants[3] !== 1'b0) begin
      errors++; $display("FAIL err_grants: got %0d frames expected s1,s1,s0,s0", grants.size());
    end
  endtask

  task automatic test_random_stall();
    do_reset(); clear_counts();
    en0 = 1; en1 = 1; stall = 1; rnd_ready = 1; drive_inputs();
    pulse_start(); wait_frames(2, 2000);
    pulse_start(); wait_frames(4, 2000);
    checks++;
    if (hs_total != 32 || stop_out !== 1'b1) begin
      errors++; $display("FAIL random_run: got beats=%0d stop=%0d expected 32 and 1", hs_total, stop_out);
    end
    stall = 0; rnd_ready = 0;
  endtask

  task automatic test_reset_mid();
    do_reset(); clear_counts();
    en0 = 1; en1 = 1; drive_inputs();
    pulse_start(); wait_beats(2, 50);
    reset = 1'b1; cycle(); reset = 1'b0;
    check_all_zero("reset_mid_frame");
    clear_counts();
    repeat (20) cycle();
    checks++;
    if (hs_total != 0) begin errors++; $display("FAIL post_reset_quiet: got %0d beats expected 0", hs_total); end
    pulse_start(); wait_frames(2, 100);
    checks++;
    if (grants.size() != 2 || grants[0] !== 1'b0 || grants[1] !== 1'b1 || hs_total != 16) begin
      errors++; $display("FAIL restart: got %0d frames %0d beats expected grants 0,1 and 16 beats",
                         grants.size(), hs_total);
    end
  endtask

  task automatic test_start_busy();
    do_reset(); clear_counts();
    en0 = 1; en1 = 0; drive_inputs();
    pulse_start(); wait_beats(3, 50);
    pulse_start();
    wait_frames(2, 100);
    repeat (20) cycle();
    checks++;
    if (frames != 2 || hs_total != 16 || stop_out !== 1'b1) begin
      errors++; $display("FAIL start_ignored: got frames=%0d beats=%0d stop=%0d expected 2 16 1",
                         frames, hs_total, stop_out);
    end
    pulse_start();
    checks++;
    if (stop_out !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_clears_stop: got stop=%0d busy=%0d expected 0 1", stop_out, busy);
    end
    wait_frames(4, 100);
    checks++;
    if (stop_out !== 1'b1 || hs_total != 32) begin
      errors++; $display("FAIL second_run: got stop=%0d beats=%0d expected 1 32", stop_out, hs_total);
    end
  endtask

  initial begin
    en0 = 0; en1 = 0; stall = 0; rnd_ready = 0; bad1 = 0;
    mg = 1'b0; last_end_cyc = 0;
    model_reset(); clear_counts(); drive_inputs();
    test_reset();
    test_single_producer();
    test_back_to_back();
    test_tlast_err();
    test_random_stall();
    test_reset_mid();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
